regfile_dump_reader: RTL



---
 rtl/regfile_dump_reader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// Scans register-file addresses 0..NREGS-1 and streams {addr, data} on valid/ready through a 2-entry fall-through buffer.
// Define REGDUMP_CHECKSUM_EN to append an XOR-of-all-words trailer word (addr 0, out_last=1) after the last register.
module regfile_dump_reader #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] infl_addr_q, infl_addr_d;
  logic          head_q, head_d;
  logic [1:0]    occ_q, occ_d;
  logic [DW-1:0] ent_data_q [2];
  logic [DW-1:0] ent_data_d [2];
  logic [AW-1:0] ent_addr_q [2];
  logic [AW-1:0] ent_addr_d [2];

  logic          rd_en_c;
  logic          tail;
  logic          pop;
  logic          buf_pop;
  logic          capture;
  logic          drain_done;
  logic          sel_vld;
  logic [DW-1:0] sel_data;
  logic [AW-1:0] sel_addr;
  logic          sel_last;

`ifdef REGDUMP_CHECKSUM_EN
  logic [DW-1:0] xor_q, xor_d;
  logic          cks_pend_q, cks_pend_d;
  logic          cks_sel;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    head_d      = head_q;
    occ_d       = occ_q;
    ent_data_d  = ent_data_q;
    ent_addr_d  = ent_addr_q;
    sel_vld     = 1'b0;
    sel_data    = '0;
    sel_addr    = '0;
    sel_last    = 1'b0;
    drain_done  = 1'b0;

    // A read may only be issued if its word is guaranteed a buffer slot.
    rd_en_c     = (state_q == S_READ) && (({1'b0, occ_q} + {2'b0, inflight_q}) < 3'd2);
    inflight_d  = rd_en_c;
    infl_addr_d = rd_en_c ? cnt_q : infl_addr_q;
    tail        = head_q ^ occ_q[0];

`ifdef REGDUMP_CHECKSUM_EN
    xor_d      = xor_q;
    cks_pend_d = cks_pend_q;
    cks_sel    = (state_q == S_DRAIN) && (occ_q == 2'd0) && !inflight_q && cks_pend_q;
`endif

    // Buffer head first; when empty, the returning read word falls straight through.
    if (occ_q != 2'd0) begin
      sel_vld  = 1'b1;
      sel_data = ent_data_q[head_q];
      sel_addr = ent_addr_q[head_q];
    end else if (inflight_q) begin
      sel_vld  = 1'b1;
      sel_data = rd_data;
      sel_addr = infl_addr_q;
    end
`ifdef REGDUMP_CHECKSUM_EN
    else if (cks_sel) begin
      sel_vld  = 1'b1;
      sel_data = xor_q;
      sel_last = 1'b1;
    end
`else
    sel_last = sel_vld && (sel_addr == LAST_ADDR);
`endif

    pop     = sel_vld && out_ready;
    buf_pop = pop && (occ_q != 2'd0);
    capture = inflight_q && ((occ_q != 2'd0) || !out_ready);

    if (capture) begin
      ent_data_d[tail] = rd_data;
      ent_addr_d[tail] = infl_addr_q;
    end
    occ_d  = occ_q + 2'(capture) - 2'(buf_pop);
    head_d = head_q ^ buf_pop;

`ifdef REGDUMP_CHECKSUM_EN
    if (inflight_q) xor_d = xor_q ^ rd_data;
    if (cks_sel && out_ready) cks_pend_d = 1'b0;
    drain_done = cks_sel && out_ready;
`else
    drain_done = (occ_d == 2'd0);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          cnt_d   = '0;
`ifdef REGDUMP_CHECKSUM_EN
          xor_d      = '0;
          cks_pend_d = 1'b1;
`endif
        end
      end
      S_READ: begin
        if (rd_en_c) begin
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == LAST_ADDR) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      head_q      <= 1'b0;
      occ_q       <= 2'd0;
      ent_data_q  <= '{default: '0};
      ent_addr_q  <= '{default: '0};
`ifdef REGDUMP_CHECKSUM_EN
      xor_q       <= '0;
      cks_pend_q  <= 1'b0;
`endif
    end else begin
      assert (!(capture && (occ_q == 2'd2)));
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      infl_addr_q <= infl_addr_d;
      head_q      <= head_d;
      occ_q       <= occ_d;
      ent_data_q  <= ent_data_d;
      ent_addr_q  <= ent_addr_d;
`ifdef REGDUMP_CHECKSUM_EN
      xor_q       <= xor_d;
      cks_pend_q  <= cks_pend_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rd_en     = rd_en_c;
  assign rd_addr   = rd_en_c ? cnt_q : '0;
  assign out_valid = sel_vld;
  assign out_data  = sel_data;
  assign out_addr  = sel_addr;
  assign out_last  = sel_last;

endmodule
